// File: rtl/frogger_pkg.sv
// Shared types and note table for the sound arbiter.
// Notes are {period, duration in ms, last-note flag}.
package frogger_pkg;

    typedef enum logic [1:0] {
        UI_PRESS    = 2'd0,
        NEXTLEVEL   = 2'd1,
        CRASH       = 2'd2,
        CELEBRATION = 2'd3
    } sound_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  dur;
        logic        last;
    } note_t;

    localparam note_t UI_N0   = '{16'h0800, 8'd30,  1'b1};
    localparam note_t NL_N0   = '{16'h0A00, 8'd60,  1'b0};
    localparam note_t NL_N1   = '{16'h0800, 8'd60,  1'b1};
    localparam note_t CR_N0   = '{16'h2000, 8'd200, 1'b1};
    localparam note_t CE_N0   = '{16'h0C00, 8'd80,  1'b0};
    localparam note_t CE_N1   = '{16'h0A00, 8'd80,  1'b0};
    localparam note_t CE_N2   = '{16'h0800, 8'd80,  1'b0};
    localparam note_t CE_N3   = '{16'h0600, 8'd160, 1'b1};
    // Unused slots terminate immediately if ever reached.
    localparam note_t NOTE_NONE = '{16'h0000, 8'd1, 1'b1};

    function automatic note_t rom_note(input logic [3:0] a);
        unique case (a)
            4'd0:    rom_note = UI_N0;
            4'd4:    rom_note = NL_N0;
            4'd5:    rom_note = NL_N1;
            4'd8:    rom_note = CR_N0;
            4'd12:   rom_note = CE_N0;
            4'd13:   rom_note = CE_N1;
            4'd14:   rom_note = CE_N2;
            4'd15:   rom_note = CE_N3;
            default: rom_note = NOTE_NONE;
        endcase
    endfunction

    function automatic logic [1:0] rank(input sound_t s);
        unique case (s)
            CRASH:       rank = 2'd3;
            CELEBRATION: rank = 2'd2;
            NEXTLEVEL:   rank = 2'd1;
            default:     rank = 2'd0;
        endcase
    endfunction

    function automatic sound_t top_sound(input logic [3:0] r);
        if (r[CRASH])            top_sound = CRASH;
        else if (r[CELEBRATION]) top_sound = CELEBRATION;
        else if (r[NEXTLEVEL])   top_sound = NEXTLEVEL;
        else                     top_sound = UI_PRESS;
    endfunction

    function automatic logic [3:0] sound_bit(input sound_t s);
        sound_bit = 4'b0001 << s;
    endfunction

endpackage

// File: rtl/sound_rom.sv
// Note table with a registered read port.
module sound_rom
    import frogger_pkg::*;
(
    input  logic       clk,
    input  logic [3:0] addr_i,
    output note_t      note_o
);

    always_ff @(posedge clk) begin
        note_o <= rom_note(addr_i);
    end

endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sequencing notes onto one shared tone generator.
// Higher-priority requests abort the current sound; lower ones wait.
module sound_arbiter
    import frogger_pkg::*;
#(
    parameter int NOTE_GAP_MS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_ms,
    input  logic [3:0]  req,
    output logic [15:0] tone_period,
    output logic        tone_en,
    output logic        busy,
    output logic [1:0]  cur_sound
);

    localparam int GW = $clog2(NOTE_GAP_MS + 1);

    state_t        state_q, state_d;
    sound_t        cur_q, cur_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    pend_q, pend_d;
    logic [7:0]    dur_q, dur_d;
    logic [GW-1:0] gap_q, gap_d;
    note_t         note;

    logic [3:0]    pend_all;
    sound_t        sel;
    sound_t        req_top;
    logic          preempt;

    sound_rom u_rom (
        .clk    (clk),
        .addr_i ({cur_q, idx_q}),
        .note_o (note)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= UI_PRESS;
            idx_q   <= '0;
            pend_q  <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
        end
    end

    assign pend_all = pend_q | req;
    assign sel      = top_sound(pend_all);
    assign req_top  = top_sound(req);
    assign preempt  = (|req) && (rank(req_top) > rank(cur_q));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        if (state_q == IDLE) begin
            if (|pend_all) begin
                cur_d   = sel;
                idx_d   = '0;
                pend_d  = pend_all & ~sound_bit(sel);
                state_d = LOAD;
                dur_d   = '0;
                gap_d   = '0;
            end
        end else begin
            // Repeats of the playing sound are coalesced away.
            pend_d = pend_q | (req & ~sound_bit(cur_q));
            if (preempt) begin
                cur_d   = req_top;
                idx_d   = '0;
                pend_d  = pend_d & ~sound_bit(req_top);
                state_d = LOAD;
                dur_d   = '0;
                gap_d   = '0;
            end else begin
                unique case (state_q)
                    LOAD: begin
                        state_d = PLAY;
                        dur_d   = '0;
                        gap_d   = '0;
                    end
                    PLAY: begin
                        if (tick_ms) begin
                            if (dur_q + 8'd1 == note.dur) begin
                                state_d = GAP;
                                dur_d   = '0;
                                gap_d   = '0;
                            end else begin
                                dur_d = dur_q + 8'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick_ms) begin
                            if (gap_q + GW'(1) == GW'(NOTE_GAP_MS)) begin
                                dur_d = '0;
                                gap_d = '0;
                                if (note.last) begin
                                    state_d = IDLE;
                                end else begin
                                    idx_d   = idx_q + 2'd1;
                                    state_d = LOAD;
                                end
                            end else begin
                                gap_d = gap_q + GW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign tone_en     = (state_q == PLAY);
    assign tone_period = tone_en ? note.period : 16'h0000;
    assign cur_sound   = cur_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Randomized and directed bench for sound_arbiter against a
// timeline model built from the note table as plain arrays.
module tb_sound_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_ms = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [15:0] tone_period;
    logic        tone_en;
    logic        busy;
    logic [1:0]  cur_sound;

    int checks = 0;
    int errors = 0;

    sound_arbiter #(.NOTE_GAP_MS(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_ms     (tick_ms),
        .req         (req),
        .tone_period (tone_period),
        .tone_en     (tone_en),
        .busy        (busy),
        .cur_sound   (cur_sound)
    );

    always #5 clk = ~clk;

    int n_cnt [4] = '{1, 2, 1, 4};
    int n_per [4][4] = '{'{'h0800, 0, 0, 0},
                         '{'h0A00, 'h0800, 0, 0},
                         '{'h2000, 0, 0, 0},
                         '{'h0C00, 'h0A00, 'h0800, 'h0600}};
    int n_dur [4][4] = '{'{30, 0, 0, 0},
                         '{60, 60, 0, 0},
                         '{200, 0, 0, 0},
                         '{80, 80, 80, 160}};
    int rnk [4] = '{0, 1, 3, 2};

    bit       m_act, m_load;
    int       m_snd, m_note, m_play, m_gap;
    bit [3:0] m_pend;

    int on_ticks, sil_ticks;
    bit tph;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int top(input bit [3:0] r);
        int best = -1;
        for (int i = 0; i < 4; i++)
            if (r[i] && (best < 0 || rnk[i] > rnk[best])) best = i;
        return best;
    endfunction

    task automatic start(input int s);
        m_act  = 1;
        m_snd  = s;
        m_note = 0;
        m_load = 1;
        m_play = 0;
        m_gap  = 0;
    endtask

    task automatic model_step(input bit [3:0] r, input bit t, input bit rs);
        int s;
        bit [3:0] pa;
        if (rs) begin
            m_act = 0; m_load = 0; m_pend = 0; m_snd = 0;
            m_note = 0; m_play = 0; m_gap = 0;
        end else if (!m_act) begin
            pa = m_pend | r;
            if (pa != 0) begin
                s = top(pa);
                m_pend = pa & ~4'(1 << s);
                start(s);
            end
        end else begin
            m_pend |= r & ~4'(1 << m_snd);
            s = top(r);
            if (s >= 0 && rnk[s] > rnk[m_snd]) begin
                m_pend &= ~4'(1 << s);
                start(s);
            end else if (m_load) begin
                m_load = 0;
                m_play = n_dur[m_snd][m_note];
            end else if (m_play > 0) begin
                if (t) begin
                    m_play--;
                    if (m_play == 0) m_gap = 10;
                end
            end else if (t) begin
                m_gap--;
                if (m_gap == 0) begin
                    if (m_note + 1 < n_cnt[m_snd]) begin
                        m_note++;
                        m_load = 1;
                    end else begin
                        m_act = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic t, input logic rs);
        bit        e_en;
        bit [15:0] e_per;
        @(negedge clk);
        req = r; tick_ms = t; reset = rs;
        if (tone_en && t) on_ticks++;
        if (busy && !tone_en && t) sil_ticks++;
        @(posedge clk);
        model_step(r, t, rs);
        #1;
        e_en  = m_act && !m_load && (m_play > 0);
        e_per = e_en ? 16'(n_per[m_snd][m_note]) : 16'h0;
        check("out", {12'h0, busy, tone_en, tone_period, cur_sound},
              {12'h0, m_act, e_en, e_per, 2'(m_snd)});
    endtask

    task automatic clr();
        on_ticks = 0;
        sil_ticks = 0;
    endtask

    task automatic run_idle(input int cap);
        int n = 0;
        while (busy && n < cap) begin
            step(4'b0, tph, 1'b0);
            tph = ~tph;
            n++;
        end
        check("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0, tph, 1'b0);
            tph = ~tph;
        end
    endtask

    initial begin
        tph = 0;
        clr();
        step(4'b0, 1'b0, 1'b1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_en", {31'h0, tone_en}, 32'h0);
        check("rst_per", {16'h0, tone_period}, 32'h0);
        check("rst_cur", {30'h0, cur_sound}, 32'h0);

        // single UI_PRESS note
        step(4'b0001, 1'b0, 1'b0);
        check("ui_busy", {31'h0, busy}, 32'h1);
        step(4'b0, 1'b0, 1'b0);
        clr();
        tph = 1;
        run_idle(2000);
        check("ui_on", on_ticks, 30);
        check("ui_gap", sil_ticks, 10);

        // two-note NEXTLEVEL
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0, 1'b0, 1'b0);
        clr();
        tph = 1;
        run_idle(2000);
        check("nl_on", on_ticks, 120);
        check("nl_gap", sil_ticks, 20);
        check("nl_cur", {30'h0, cur_sound}, 32'h1);

        // CRASH preempts NEXTLEVEL, which is discarded
        step(4'b0010, 1'b0, 1'b0);
        run_n(40);
        step(4'b0100, 1'b0, 1'b0);
        check("pre_cur", {30'h0, cur_sound}, 32'h2);
        clr();
        run_idle(3000);
        check("pre_on", on_ticks, 200);

        // simultaneous CELEBRATION and UI_PRESS
        clr();
        step(4'b1001, 1'b0, 1'b0);
        check("sim_cur", {30'h0, cur_sound}, 32'h3);
        run_idle(5000);
        run_n(2);
        run_idle(2000);
        check("sim_on", on_ticks, 430);
        check("sim_last", {30'h0, cur_sound}, 32'h0);

        // CRASH repeat coalesced, UI_PRESS waits
        clr();
        step(4'b0100, 1'b0, 1'b0);
        run_n(20);
        step(4'b0100, 1'b0, 1'b0);
        run_n(20);
        step(4'b0001, 1'b0, 1'b0);
        run_idle(3000);
        run_n(2);
        run_idle(2000);
        check("coal_on", on_ticks, 230);

        // reset mid-note
        clr();
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 200 && on_ticks < 15; i++) begin
            step(4'b0, tph, 1'b0);
            tph = ~tph;
        end
        check("mid_ticks", on_ticks, 15);
        step(4'b0, 1'b0, 1'b1);
        check("mid_busy", {31'h0, busy}, 32'h0);
        check("mid_en", {31'h0, tone_en}, 32'h0);
        clr();
        run_n(60);
        check("mid_quiet", on_ticks + sil_ticks, 0);

        // randomized traffic
        for (int i = 0; i < 20000; i++) begin
            logic [3:0] r;
            r = 4'b0;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 299) == 0) r[b] = 1'b1;
            step(r, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4999) == 0);
        end
        step(4'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 SHALL have parameter NOTE_GAP_MS, default 10, meaning the number of silent ms ticks between consecutive notes.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tick_ms, input, 1 bit: one-cycle pulse at 1 kHz; it is the only time base for note durations.
REQ-005 SHALL have port req, input, 4 bits: one-cycle request pulses; bit0 UI_PRESS, bit1 NEXTLEVEL, bit2 CRASH, bit3 CELEBRATION.
REQ-006 SHALL have port tone_period, output, 16 bits: half-period count for the shared square-wave tone generator.
REQ-007 SHALL have port tone_en, output, 1 bit: tone generator enable.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port cur_sound, output, 2 bits: encoding of the sound playing (0 UI_PRESS, 1 NEXTLEVEL, 2 CRASH, 3 CELEBRATION); holds its last value when idle.

Function
REQ-010 SHALL hold a 4-bit pending register; a req bit sets its pending bit on the same edge.
REQ-011 SHALL use fixed priority CRASH > CELEBRATION > NEXTLEVEL > UI_PRESS.
REQ-012 SHALL implement states IDLE, LOAD, PLAY and GAP.
REQ-013 IDLE: if any pending bit (or incoming req) is set, SHALL select the highest-priority one, clear that pending bit, set cur_sound, reset the note index to 0 and go to LOAD.
REQ-014 LOAD: SHALL spend one cycle on the registered ROM read of {period[15:0], dur_ms[7:0], last}, then go to PLAY.
REQ-015 PLAY: SHALL drive tone_en=1 and tone_period=ROM period, count tick_ms pulses, and go to GAP on the tick that brings the count to dur_ms.
REQ-016 GAP: SHALL drive tone_en=0 for NOTE_GAP_MS ticks; then, if last=0, increment the note index and go to LOAD; otherwise go to IDLE.
REQ-017 Preemption: a req of strictly higher priority than cur_sound in LOAD/PLAY/GAP SHALL abort the current sound on that edge and enter LOAD for the new sound, with index 0 and its pending bit cleared.
REQ-018 An aborted sound SHALL be discarded, not resumed.
REQ-019 A lower-priority req during playback SHALL remain pending until IDLE.
REQ-020 A req equal to cur_sound during playback SHALL be dropped (coalesced).
REQ-021 Simultaneous req bits: the highest SHALL be served, and the rest SHALL stay pending.
REQ-022 The duration counter SHALL be 8 bits and the gap counter SHALL be ceil(log2(NOTE_GAP_MS+1)) bits; both SHALL clear on every state entry.
REQ-023 ROM contents: each sound SHALL have at most 4 notes, addressed by {sound[1:0], index[1:0]}; index SHALL not wrap past a last=1 entry.
REQ-024 tone_period SHALL be 0 whenever tone_en=0.

Reset
REQ-025 On reset: state=IDLE, pending=0, counters=0, tone_en=0, tone_period=0, busy=0, cur_sound=0; these values SHALL be visible after the first reset edge.
REQ-026 Reset SHALL override req on the same edge, and a req pulse coincident with reset SHALL be lost.
REQ-027 Reset mid-note SHALL silence the output with no gap.

Structure
REQ-028 The shared package (frogger_pkg) SHALL hold the sound_t enum (UI_PRESS, NEXTLEVEL, CRASH, CELEBRATION), the state typedef and the ROM note constants.
REQ-029 The note table SHALL be a sub-module, sound_rom: 4-bit address, registered 25-bit output.
REQ-030 ROM contents SHALL be: UI_PRESS {0x0800,30,1}; NEXTLEVEL {0x0A00,60,0},{0x0800,60,1}; CRASH {0x2000,200,1}; CELEBRATION {0x0C00,80,0},{0x0A00,80,0},{0x0800,80,0},{0x0600,160,1}.

Verification
REQ-031 Reset then req=0001 -> busy the next cycle; tone_en=1 with period 0x0800 for exactly 30 ticks, then 10 silent ticks, then busy=0.
REQ-032 req=0010 -> 0x0A00 for 60 ticks, 10-tick gap, 0x0800 for 60 ticks, gap, idle; cur_sound=1 throughout.
REQ-033 Mid-NEXTLEVEL req=0100 -> the next state is LOAD of CRASH, 0x2000 for 200 ticks, and NEXTLEVEL never resumes.
REQ-034 req=1001 in a single cycle -> CELEBRATION plays all 4 notes, then UI_PRESS plays.
REQ-035 During CRASH, req=0100 and req=0001 -> CRASH is not restarted, and UI_PRESS plays once after CRASH.
REQ-036 Reset asserted at tick 15 of UI_PRESS -> tone_en=0, busy=0 and pending=0 on the next cycle, with no further output.
